and_64bit: RTL and testbench

//   64-bit bitwise-AND execution unit for the Y86-64 ALU (andq datapath).

---
 rtl/and_64bit_if.sv | 56 +++++
 rtl/and_64bit.sv | 66 ++++++
 tb/tb_and_64bit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/and_64bit_if.sv
// ---------------------------------------------------------------------------
// and_64bit_if
//   Operand/result bundle for the andq execution unit.
//   Config macro: AND64_CC_EN adds the zf/sf/of condition-code signals.
//   Signals:
//     in_valid        operands valid this cycle        (master -> slave)
//     in1, in2        signed operands                  (master -> slave)
//     out_valid       out carries a new result         (slave  -> master)
//     out             registered in1 & in2, signed     (slave  -> master)
//     zf, sf, of      condition codes (AND64_CC_EN)    (slave  -> master)
//   Modports:
//     master  drives operands (ALU issue side / bench)
//     slave   the execution unit itself
// ---------------------------------------------------------------------------
interface and_64bit_if #(
  parameter int unsigned WIDTH = 64
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] in1;
  logic signed [WIDTH-1:0] in2;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out;
`ifdef AND64_CC_EN
  logic                    zf;
  logic                    sf;
  logic                    of;
`endif

  modport master (
    output in_valid,
    output in1,
    output in2,
    input  out_valid,
    input  out
`ifdef AND64_CC_EN
    ,
    input  zf,
    input  sf,
    input  of
`endif
  );

  modport slave (
    input  in_valid,
    input  in1,
    input  in2,
    output out_valid,
    output out
`ifdef AND64_CC_EN
    ,
    output zf,
    output sf,
    output of
`endif
  );
endinterface

// File: rtl/and_64bit.sv
// ---------------------------------------------------------------------------
// and_64bit
//   64-bit bitwise-AND execution unit for the Y86-64 ALU (andq datapath).
//   One-cycle registered result with a valid strobe; no backpressure, so an
//   unconsumed result is simply overwritten by the next one.
//   Config macro: AND64_CC_EN -- when defined, registers zf/sf alongside the
//   result and ties of to 0 (logical ops never overflow in Y86).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (release synchronised externally)
//     bus    and_64bit_if.slave: in_valid/in1/in2 in, out_valid/out
//            (and zf/sf/of with AND64_CC_EN) out
//   Parameter WIDTH: only 64 is supported; sf is taken from bit WIDTH-1.
// ---------------------------------------------------------------------------
module and_64bit #(
  parameter int unsigned WIDTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  and_64bit_if.slave bus
);

  logic signed [WIDTH-1:0] w_and;
  logic signed [WIDTH-1:0] r_out;
  logic                    r_out_valid;

  // Signedness is declarative only; AND is the same bit operation either way.
  assign w_and = bus.in1 & bus.in2;

  // out only loads on valid cycles, so X on idle operands never propagates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out <= w_and;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;

`ifdef AND64_CC_EN
  logic r_zf;
  logic r_sf;

  // zf resets to 1 to agree with the cleared (zero) result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
    end else if (bus.in_valid) begin
      r_zf <= (w_and == '0);
      r_sf <= w_and[WIDTH-1];
    end
  end

  assign bus.zf = r_zf;
  assign bus.sf = r_sf;
  assign bus.of = 1'b0;
`endif

endmodule

// File: tb/tb_and_64bit.sv
// ---------------------------------------------------------------------------
// tb_and_64bit
//   Scoreboard bench for and_64bit: the stimulus process pushes hand-computed
//   expected results; a monitor on the falling edge pops and compares each
//   time out_valid is seen, and also checks out_valid cycle by cycle.
//   Build with +define+AND64_CC_EN to exercise zf/sf/of as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_and_64bit;

  typedef struct {
    logic [63:0] out;
    logic        zf;
    logic        sf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb[$];
  logic tb_v;   // expected out_valid: in_valid seen at the last posedge

  and_64bit_if #(.WIDTH(64)) bus ();

  and_64bit #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_v <= 1'b0;
    else        tb_v <= bus.in_valid;
  end

  // Monitor
  always @(negedge clk) begin
    check("out_valid", {63'd0, bus.out_valid}, {63'd0, tb_v});
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", bus.out, e.out);
`ifdef AND64_CC_EN
        check("zf", {63'd0, bus.zf}, {63'd0, e.zf});
        check("sf", {63'd0, bus.sf}, {63'd0, e.sf});
        check("of", {63'd0, bus.of}, 64'd0);
`endif
      end
    end
  end

  // Issue one operand pair at posedge+1; leaves time at next posedge+1.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in1      = a;
    bus.in2      = b;
    e.out = r;
    e.zf  = (r == 64'd0);
    e.sf  = r[63];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out"}, bus.out, 64'd0);
    check({name, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
`ifdef AND64_CC_EN
    check({name, "_zf"}, {63'd0, bus.zf}, 64'd1);
    check({name, "_sf"}, {63'd0, bus.sf}, 64'd0);
`endif
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // 1: reset held while valid nonzero operands are presented
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in1      = 64'h1234_5678_9ABC_DEF0;
    bus.in2      = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_reset_state("reset_hold");
    end
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2-4: directed vectors, issued back-to-back
    send(64'b100110, 64'b110001, 64'd32);
    send(64'b001110, 64'b101000, 64'd8);
    send(-64'sd45, 64'sd21, 64'd17);
    send(-64'sd33, -64'sd34, 64'hFFFF_FFFF_FFFF_FFDE);
    send(64'b101111, 64'b111001, 64'd41);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    send(64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_FFFF_0000, 64'hAAAA_0000_AAAA_0000);
    // 5: zero result, then idle with garbage operands
    send(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    bus.in_valid = 1'b0;
    bus.in1      = 64'hDEAD_BEEF_CAFE_F00D;
    bus.in2      = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      check("hold_out", bus.out, 64'd0);
`ifdef AND64_CC_EN
      check("hold_zf", {63'd0, bus.zf}, 64'd1);
`endif
    end
    @(posedge clk);
    #1;

    // 6: asynchronous reset between edges with a result just registered
    send(64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF, 64'h000F_000F_000F_000F);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    sb.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_state("async_reset_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_valid_after_reset", {63'd0, bus.out_valid}, 64'd0);

    // recovery after reset
    send(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0003, 64'h8000_0000_0000_0001);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
